// File: rtl/dram_bank_timer_pkg.sv
// Shared definitions for the DRAM bank timer: command codes, FSM states,
// default geometry/timing and small helpers.
package dram_bank_timer_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXEC     = 2'b01,
        ST_ACK      = 2'b10,
        ST_WAIT_LOW = 2'b11
    } state_t;

    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_T_RCD        = 3;
    localparam int DEF_T_RP         = 3;
    localparam int DEF_T_CAS        = 2;
    localparam int DEF_BURST_LEN    = 8;

    // Index width for a one-hot vector of n bits; a 1-bit vector still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cycles spent in EXEC for a command; illegal commands are rejected after one cycle.
    function automatic int lat_load(input cmd_t c, input logic illegal, input int t_rcd,
                                    input int t_rp, input int t_cas, input int burst_len);
        if (illegal) return 1;
        case (c)
            CMD_ACT: return t_rcd;
            CMD_PRE: return t_rp;
            default: return t_cas + burst_len;
        endcase
    endfunction

endpackage

// File: rtl/dram_bank_timer_if.sv
// Command bus between a memory controller (master) and the bank timer (slave).
interface dram_bank_timer_if
    import dram_bank_timer_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS
) ();
    localparam int BW  = idx_w(NUM_OF_BANKS);
    localparam int RW  = idx_w(NUM_OF_ROWS);
    localparam int CLW = idx_w(NUM_OF_COLS);

    logic                    cmd_req;
    logic [1:0]              cmd;
    logic [NUM_OF_BANKS-1:0] bank_sel;
    logic [NUM_OF_ROWS-1:0]  row_sel;
    logic [NUM_OF_COLS-1:0]  col_sel;
    logic                    cmd_ack;
    logic                    cmd_err;
    logic [NUM_OF_BANKS-1:0] bank_open;
    logic                    busy;
    // Encoded address of the command in flight, for the column datapath.
    logic [BW-1:0]           addr_bank;
    logic [RW-1:0]           addr_row;
    logic [CLW-1:0]          addr_col;

    modport master (
        output cmd_req, cmd, bank_sel, row_sel, col_sel,
        input  cmd_ack, cmd_err, bank_open, busy, addr_bank, addr_row, addr_col
    );

    modport slave (
        input  cmd_req, cmd, bank_sel, row_sel, col_sel,
        output cmd_ack, cmd_err, bank_open, busy, addr_bank, addr_row, addr_col
    );

endinterface

// File: rtl/dram_onehot_enc.sv
// One-hot to binary encoder; o_valid is set only when exactly one bit is high.
module dram_onehot_enc
    import dram_bank_timer_pkg::*;
#(
    parameter int W  = 8,
    parameter int IW = idx_w(W)
) (
    input  logic [W-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // OR of set-bit positions: exact for one-hot input, don't-care otherwise.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) o_idx = o_idx | IW'(i);
        end
    end

    // Nonzero and a power of two means exactly one bit set.
    assign o_valid = (i_vec != '0) && ((i_vec & (i_vec - W'(1))) == '0);

endmodule

// File: rtl/dram_bank_timer.sv
// Per-bank open/closed tracking with ACT/RD/WR/PRE latency timing and a
// req/ack handshake that waits for the request to drop before re-arming.
module dram_bank_timer
    import dram_bank_timer_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CAS        = DEF_T_CAS,
    parameter int BURST_LEN    = DEF_BURST_LEN
) (
    input logic              clk,
    input logic              rst,
    dram_bank_timer_if.slave bus
);
    localparam int BW  = idx_w(NUM_OF_BANKS);
    localparam int RW  = idx_w(NUM_OF_ROWS);
    localparam int CLW = idx_w(NUM_OF_COLS);
    localparam int CW  = $clog2(T_CAS + BURST_LEN + 1);

    state_t                           r_state, w_state_nxt;
    cmd_t                             r_cmd, w_cmd;
    logic [BW-1:0]                    r_bank, w_bidx;
    logic [RW-1:0]                    r_row, w_ridx;
    logic [CLW-1:0]                   r_col, w_cidx;
    logic [CW-1:0]                    r_cnt, w_load;
    logic                             r_err, r_pre_all;
    logic                             w_bv, w_rv, w_cv;
    logic                             w_illegal, w_pre_all, w_sample, w_done;
    logic [NUM_OF_BANKS-1:0]          r_open;
    logic [NUM_OF_BANKS-1:0][RW-1:0]  r_rows;

    assign w_cmd = cmd_t'(bus.cmd);

    dram_onehot_enc #(.W(NUM_OF_BANKS), .IW(BW)) u_enc_bank (
        .i_vec(bus.bank_sel), .o_idx(w_bidx), .o_valid(w_bv));
    dram_onehot_enc #(.W(NUM_OF_ROWS), .IW(RW)) u_enc_row (
        .i_vec(bus.row_sel), .o_idx(w_ridx), .o_valid(w_rv));
    dram_onehot_enc #(.W(NUM_OF_COLS), .IW(CLW)) u_enc_col (
        .i_vec(bus.col_sel), .o_idx(w_cidx), .o_valid(w_cv));

    // Legality is decided at sample time: bank state only moves in the ACK cycle,
    // so it cannot change between sampling and completion.
    always_comb begin
        w_pre_all = (w_cmd == CMD_PRE) && (&bus.bank_sel);
        w_illegal = 1'b0;
        case (w_cmd)
            CMD_ACT:        w_illegal = !w_bv || !w_rv || r_open[w_bidx];
            CMD_RD, CMD_WR: w_illegal = !w_bv || !w_rv || !w_cv || !r_open[w_bidx] ||
                                        (r_rows[w_bidx] != w_ridx);
            default:        w_illegal = !w_pre_all && !w_bv;
        endcase
    end

    assign w_load = CW'(lat_load(w_cmd, w_illegal, T_RCD, T_RP, T_CAS, BURST_LEN));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_req) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == CW'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:      w_state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!bus.cmd_req) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        bus.cmd_ack = (r_state == ST_ACK);
        bus.cmd_err = (r_state == ST_ACK) && r_err;
        bus.busy    = (r_state != ST_IDLE);
    end

    // Command latch, latency counter and bank state; bank updates land on the
    // edge into ACK so bank_open already reflects the command while ack is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd     <= CMD_ACT;
            r_bank    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_pre_all <= 1'b0;
            r_open    <= '0;
            r_rows    <= '0;
        end else begin
            if (w_sample) begin
                r_cmd     <= w_cmd;
                r_bank    <= w_bidx;
                r_row     <= w_ridx;
                r_col     <= w_cidx;
                r_cnt     <= w_load;
                r_err     <= w_illegal;
                r_pre_all <= w_pre_all;
            end else if (r_state == ST_EXEC && r_cnt != CW'(1)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_done && !r_err) begin
                case (r_cmd)
                    CMD_ACT: begin
                        r_open[r_bank] <= 1'b1;
                        r_rows[r_bank] <= r_row;
                    end
                    CMD_PRE: begin
                        if (r_pre_all) r_open <= '0;
                        else           r_open[r_bank] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bank_open = r_open;
    assign bus.addr_bank = r_bank;
    assign bus.addr_row  = r_row;
    assign bus.addr_col  = r_col;

endmodule

// File: doc/dram_bank_timer.md
DRAM_BANK_TIMER -- requirements
Module: dram_bank_timer

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 8, number of banks (one-hot bank_sel width).
REQ-002 SHALL have parameter NUM_OF_ROWS, default 128, rows per bank (one-hot row_sel width).
REQ-003 SHALL have parameter NUM_OF_COLS, default 8, columns per row (one-hot col_sel width).
REQ-004 SHALL have parameters T_RCD=3, T_RP=3, T_CAS=2, BURST_LEN=8: cycle counts, each >=1.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmd_req  in  1  command request from controller, held high until acknowledged.
REQ-008 SHALL have port cmd  in  2  command code: 00 ACT, 01 RD, 10 WR, 11 PRE.
REQ-009 SHALL have port bank_sel  in  NUM_OF_BANKS  one-hot bank select.
REQ-010 SHALL have port row_sel  in  NUM_OF_ROWS  one-hot row select.
REQ-011 SHALL have port col_sel  in  NUM_OF_COLS  one-hot column select.
REQ-012 SHALL have port cmd_ack  out  1  one-cycle acknowledge pulse.
REQ-013 SHALL have port cmd_err  out  1  one-cycle error pulse, coincident with cmd_ack.
REQ-014 SHALL have port bank_open  out  NUM_OF_BANKS  bit i high while bank i has an open row.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, ACK, WAIT_LOW.
REQ-017 IDLE: on cmd_req=1, SHALL latch cmd, bank index, row index and column index (encoded from the one-hot inputs), load the latency counter and go to EXEC the next cycle.
REQ-018 Latency counter load SHALL be: ACT T_RCD; RD/WR T_CAS+BURST_LEN; PRE T_RP; illegal 1.
REQ-019 EXEC SHALL decrement the counter each cycle and go to ACK when the counter reaches 1.
REQ-020 ACK SHALL drive cmd_ack=1 for exactly one cycle, then go to WAIT_LOW.
REQ-021 WAIT_LOW SHALL return to IDLE when cmd_req=0; a new request SHALL NOT be sampled in the same cycle.
REQ-022 Bank state updates SHALL take effect in the ACK cycle: ACT sets bank_open[b] and stores the row index; PRE clears bank_open[b].
REQ-023 PRE with bank_sel all ones SHALL be precharge-all: it clears every bank and is never illegal.
REQ-024 A command SHALL be illegal if:
  - a select input required by the command is not one-hot (ACT: bank, row; RD/WR: bank, row, col; PRE: bank), or
  - ACT targets an open bank, or
  - RD/WR targets a closed bank, or
  - RD/WR row_sel differs from the stored open row.
REQ-025 An illegal command SHALL raise cmd_err with cmd_ack, SHALL leave all bank state unchanged, and SHALL use latency 1.
REQ-026 PRE to a closed bank SHALL be legal and a no-op.
REQ-027 Request-to-ack latency, measured from the IDLE sampling edge to the cmd_ack cycle, SHALL be (load + 1) cycles: ACT 4, RD 11, PRE 4, illegal 2 with default parameters.
REQ-028 Changes on cmd, bank_sel, row_sel or col_sel after sampling SHALL be ignored until the next IDLE sample.
REQ-029 Counter width SHALL be $clog2(T_CAS+BURST_LEN+1); index widths SHALL be $clog2 of the matching parameter.

Reset
REQ-030 Asserting rst at any time, including mid-EXEC, SHALL immediately force IDLE and set cmd_ack=0, cmd_err=0, busy=0, bank_open=0, all stored rows=0 and counter=0.
REQ-031 After rst deasserts, the first request SHALL be sampled no earlier than the first rising edge with rst=0.

Structure
REQ-032 The command encodings (ACT/RD/WR/PRE), FSM state encodings and default timing constants SHALL live in the shared dram package and be used by the controller FSM as well.
REQ-033 One sub-module, dram_onehot_enc, SHALL be used (instantiated three times). It converts a one-hot vector to an index plus a valid flag, where valid means exactly one bit is set.

Verification
REQ-034 Reset, then ACT bank_sel=0x04 row_sel bit 5 -> cmd_ack at sample+4, cmd_err=0, bank_open=0x04.
REQ-035 After REQ-034, RD bank 2, row 5, col_sel=0x01 -> cmd_ack at sample+11, cmd_err=0, bank_open unchanged.
REQ-036 RD bank 2 with row_sel bit 6 (row mismatch) -> cmd_ack and cmd_err at sample+2, bank_open=0x04.
REQ-037 ACT bank_sel=0x06 (not one-hot) -> cmd_err at sample+2; cmd_req held high 5 more cycles -> no second ack until cmd_req drops and a new request is sampled.
REQ-038 With banks 2 and 7 open, PRE bank_sel=0xFF -> cmd_ack at sample+4, bank_open=0x00.
REQ-039 rst pulsed at cycle 3 of a RD EXEC -> busy=0, bank_open=0 immediately, no cmd_ack emitted; a new ACT then completes normally.
